// File: rtl/instr_issue_queue.sv
// Instruction issue queue: encodes pushed instruction fields into a word, buffers them in a
// circular FIFO and hands one word to the CPU per done-high period. Optional monitor: INSTR_ISSUE_MON_EN.
module instr_issue_queue #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 3,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [3:0]                     in_opcode,
    input  logic [REG_AW-1:0]              in_first,
    input  logic [REG_AW-1:0]              in_second,
    input  logic [REG_AW-1:0]              in_target,
    input  logic [DATA_W-5:0]              in_offset,
    input  logic [DATA_W-4-REG_AW-1:0]     in_imm,
    input  logic                           flush,
    input  logic                           done,
    output logic [DATA_W-1:0]              dout,
    output logic                           issued,
    output logic [$clog2(DEPTH+1)-1:0]     level,
    output logic                           empty
`ifdef INSTR_ISSUE_MON_EN
    ,
    output logic                           mon_valid,
    output logic [DATA_W-1:0]              mon_word,
    output logic [15:0]                    issue_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned T_LSB = DATA_W - 4 - REG_AW;
    localparam int unsigned F_LSB = T_LSB - REG_AW;
    localparam int unsigned S_LSB = F_LSB - REG_AW;

    typedef enum logic {
        ST_READY = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_W-1:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]        level_q;
    logic [DATA_W-1:0]       dout_q;
    logic                    issued_q;
    logic [DATA_W-1:0]       enc_word_c;
    logic                    push_c;
    logic                    pop_c;

    // Field packing; every bit not owned by the opcode's format stays zero.
    always_comb begin
        enc_word_c                 = '0;
        enc_word_c[DATA_W-1 -: 4]  = in_opcode;
        case (in_opcode)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
                enc_word_c[T_LSB +: REG_AW] = in_target;
                enc_word_c[F_LSB +: REG_AW] = in_first;
                enc_word_c[S_LSB +: REG_AW] = in_second;
            end
            4'h7, 4'h8, 4'h9: begin
                enc_word_c[T_LSB +: REG_AW] = in_target;
                enc_word_c[F_LSB +: REG_AW] = in_first;
            end
            4'hA: begin
                enc_word_c[F_LSB +: REG_AW] = in_first;
                enc_word_c[S_LSB +: REG_AW] = in_second;
            end
            4'hB: begin
                enc_word_c[T_LSB +: REG_AW] = in_target;
                enc_word_c[T_LSB-1:0]       = in_imm;
            end
            default: enc_word_c[DATA_W-5:0] = in_offset;
        endcase
    end

    assign in_ready = (level_q != LVL_W'(DEPTH));
    assign push_c   = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_READY;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush freezes the FSM so a discarded queue never changes the issue handshake.
    always_comb begin
        state_d = state_q;
        if (!flush) begin
            case (state_q)
                ST_READY: if (pop_c) state_d = ST_HOLD;
                ST_HOLD:  if (!done) state_d = ST_READY;
                default:  state_d = ST_READY;
            endcase
        end
    end

    always_comb begin
        pop_c = 1'b0;
        if ((state_q == ST_READY) && done && (level_q != '0) && !flush) begin
            pop_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= enc_word_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            dout_q   <= '0;
            issued_q <= 1'b0;
        end else begin
            issued_q <= pop_c;
            if (pop_c) begin
                dout_q <= mem_q[rd_ptr_q];
            end
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else begin
                if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                case ({push_c, pop_c})
                    2'b10:   level_q <= level_q + LVL_W'(1);
                    2'b01:   level_q <= level_q - LVL_W'(1);
                    default: level_q <= level_q;
                endcase
            end
        end
    end

    assign dout   = dout_q;
    assign issued = issued_q;
    assign level  = level_q;
    assign empty  = (level_q == '0);

`ifdef INSTR_ISSUE_MON_EN
    logic [15:0] issue_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_cnt_q <= '0;
        end else if (pop_c) begin
            issue_cnt_q <= issue_cnt_q + 16'(1);
        end
    end

    assign mon_valid = issued_q;
    assign mon_word  = dout_q;
    assign issue_cnt = issue_cnt_q;
`endif

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed bench for instr_issue_queue (DATA_W=16, REG_AW=3, DEPTH=4); define INSTR_ISSUE_MON_EN
// on both files to also cover the monitor ports.
module tb_instr_issue_queue;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_AW = 3;
    localparam int unsigned DEPTH  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [2:0]  in_first, in_second, in_target;
    logic [11:0] in_offset;
    logic [8:0]  in_imm;
    logic        flush;
    logic        done;
    logic [15:0] dout;
    logic        issued;
    logic [2:0]  level;
    logic        empty;
`ifdef INSTR_ISSUE_MON_EN
    logic        mon_valid;
    logic [15:0] mon_word;
    logic [15:0] issue_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_issue_queue #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_first(in_first), .in_second(in_second), .in_target(in_target),
        .in_offset(in_offset), .in_imm(in_imm), .flush(flush), .done(done),
        .dout(dout), .issued(issued), .level(level), .empty(empty)
`ifdef INSTR_ISSUE_MON_EN
        , .mon_valid(mon_valid), .mon_word(mon_word), .issue_cnt(issue_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [3:0] op, input logic [2:0] t, input logic [2:0] f,
                             input logic [2:0] s, input logic [11:0] off, input logic [8:0] imm);
        in_opcode = op; in_target = t; in_first = f; in_second = s; in_offset = off; in_imm = imm;
    endtask

    task automatic push_one(input logic [3:0] op, input logic [2:0] t, input logic [2:0] f,
                            input logic [2:0] s, input logic [11:0] off, input logic [8:0] imm);
        set_instr(op, t, f, s, off, imm);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; done = 1'b0;
        set_instr(4'h0, 3'h0, 3'h0, 3'h0, 12'h0, 9'h0);
        step(); step();
        checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL reset_dout got %h exp 0000", dout); end
        checks++; if (issued !== 1'b0) begin errors++; $display("FAIL reset_issued got %b exp 0", issued); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_add();
        push_one(4'h0, 3'd1, 3'd2, 3'd3, 12'h000, 9'h000);
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL add_level_pre got %0d exp 1", level); end
        done = 1'b1;
        step();
        checks++; if (dout !== 16'h0298) begin errors++; $display("FAIL add_dout got %h exp 0298", dout); end
        checks++; if (issued !== 1'b1) begin errors++; $display("FAIL add_issued got %b exp 1", issued); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL add_level_post got %0d exp 0", level); end
        step();
        checks++; if (issued !== 1'b0) begin errors++; $display("FAIL add_pulse_width got %b exp 0", issued); end
        checks++; if (dout !== 16'h0298) begin errors++; $display("FAIL add_dout_hold got %h exp 0298", dout); end
        done = 1'b0;
        step();
    endtask

    task automatic test_encode();
        logic [3:0]  v_op  [8] = '{4'h0, 4'hB, 4'hA, 4'hC, 4'h7, 4'h9, 4'h6, 4'hF};
        logic [2:0]  v_t   [8] = '{3'd1, 3'd5, 3'd7, 3'd7, 3'd3, 3'd6, 3'd2, 3'd7};
        logic [2:0]  v_f   [8] = '{3'd2, 3'd2, 3'd2, 3'd7, 3'd4, 3'd1, 3'd5, 3'd7};
        logic [2:0]  v_s   [8] = '{3'd3, 3'd3, 3'd3, 3'd7, 3'd5, 3'd7, 3'd1, 3'd7};
        logic [11:0] v_off [8] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hABC, 12'hFFF, 12'hFFF, 12'hFFF, 12'h123};
        logic [15:0] v_exp [8] = '{16'h0298, 16'hBBFF, 16'hA098, 16'hCABC, 16'h7700, 16'h9C40, 16'h6548, 16'hF123};
        for (int i = 0; i < 8; i++) begin
            push_one(v_op[i], v_t[i], v_f[i], v_s[i], v_off[i], 9'h1FF);
            done = 1'b1;
            step();
            checks++;
            if (issued !== 1'b1 || dout !== v_exp[i]) begin
                errors++;
                $display("FAIL encode_%0d got issued=%b dout=%h exp issued=1 dout=%h", i, issued, dout, v_exp[i]);
            end
            done = 1'b0;
            step();
        end
    endtask

    task automatic test_full();
        logic [15:0] got [4];
        int n = 0;
        done = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            set_instr(4'h8, 3'(i), 3'(i), 3'd0, 12'h0, 9'h0);
            in_valid = 1'b1;
            step();
            if (i == 4) begin
                checks++;
                if (in_ready !== 1'b0 || level !== 3'd4) begin
                    errors++; $display("FAIL full_flag got in_ready=%b level=%0d exp 0/4", in_ready, level);
                end
            end
        end
        in_valid = 1'b0;
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_fifth_lost got %0d exp 4", level); end
        done = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            if (issued === 1'b1) begin if (n < 4) got[n] = dout; n++; end
        end
        done = 1'b0; step();
        done = 1'b1; step();
        if (issued === 1'b1) begin if (n < 4) got[n] = dout; n++; end
        done = 1'b0; step();
        checks++; if (n != 2) begin errors++; $display("FAIL full_issue_count got %0d exp 2", n); end
        checks++; if (n >= 1 && got[0] !== 16'h8240) begin errors++; $display("FAIL full_order0 got %h exp 8240", got[0]); end
        checks++; if (n >= 2 && got[1] !== 16'h8480) begin errors++; $display("FAIL full_order1 got %h exp 8480", got[1]); end
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL full_level_left got %0d exp 2", level); end
    endtask

    task automatic test_flush();
        push_one(4'h9, 3'd6, 3'd1, 3'd0, 12'h0, 9'h0);
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL flush_level_pre got %0d exp 3", level); end
        set_instr(4'h0, 3'd1, 3'd2, 3'd3, 12'h0, 9'h0);
        flush = 1'b1; done = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        checks++; if (level !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush_level got %0d/%b exp 0/1", level, empty); end
        checks++; if (issued !== 1'b0) begin errors++; $display("FAIL flush_issued got %b exp 0", issued); end
        checks++; if (dout !== 16'h8480) begin errors++; $display("FAIL flush_dout got %h exp 8480", dout); end
        step();
        checks++; if (issued !== 1'b0) begin errors++; $display("FAIL flush_empty_done got %b exp 0", issued); end
        done = 1'b0; step();
        push_one(4'h0, 3'd1, 3'd2, 3'd3, 12'h0, 9'h0);
        done = 1'b1; step();
        checks++; if (issued !== 1'b1 || dout !== 16'h0298) begin errors++; $display("FAIL flush_recover got %b/%h exp 1/0298", issued, dout); end
        done = 1'b0; step();
    endtask

    task automatic test_back_to_back();
        set_instr(4'h1, 3'd2, 3'd3, 3'd4, 12'h0, 9'h0);
        in_valid = 1'b1; done = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (issued !== 1'b0 || level !== 3'd1) begin errors++; $display("FAIL latency_first got %b/%0d exp 0/1", issued, level); end
        step();
        checks++; if (issued !== 1'b1 || dout !== 16'h14E0 || level !== 3'd0) begin
            errors++; $display("FAIL latency_second got %b/%h/%0d exp 1/14e0/0", issued, dout, level);
        end
        done = 1'b0; step();
        push_one(4'h2, 3'd3, 3'd4, 3'd5, 12'h0, 9'h0);
        set_instr(4'h3, 3'd4, 3'd5, 3'd6, 12'h0, 9'h0);
        in_valid = 1'b1; done = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (issued !== 1'b1 || dout !== 16'h2728 || level !== 3'd1) begin
            errors++; $display("FAIL pushpop got %b/%h/%0d exp 1/2728/1", issued, dout, level);
        end
        done = 1'b0; step();
        done = 1'b1; step();
        checks++; if (issued !== 1'b1 || dout !== 16'h3970) begin errors++; $display("FAIL pushpop_next got %b/%h exp 1/3970", issued, dout); end
        done = 1'b0; step();
    endtask

    task automatic test_reset_hold();
        for (int i = 1; i <= 3; i++) push_one(4'h8, 3'(i), 3'(i), 3'd0, 12'h0, 9'h0);
        done = 1'b1; step();
        checks++; if (issued !== 1'b1 || level !== 3'd2) begin errors++; $display("FAIL hold_setup got %b/%0d exp 1/2", issued, level); end
        reset = 1'b1; step();
        checks++; if (dout !== 16'h0000 || level !== 3'd0 || empty !== 1'b1 || issued !== 1'b0) begin
            errors++; $display("FAIL hold_reset got %h/%0d/%b/%b exp 0000/0/1/0", dout, level, empty, issued);
        end
        reset = 1'b0; done = 1'b0;
        push_one(4'h0, 3'd1, 3'd2, 3'd3, 12'h0, 9'h0);
        done = 1'b1; step();
        checks++; if (issued !== 1'b1 || dout !== 16'h0298) begin errors++; $display("FAIL hold_after_reset got %b/%h exp 1/0298", issued, dout); end
`ifdef INSTR_ISSUE_MON_EN
        checks++; if (issue_cnt !== 16'd1) begin errors++; $display("FAIL mon_issue_cnt got %0d exp 1", issue_cnt); end
        checks++; if (mon_valid !== 1'b1 || mon_word !== 16'h0298) begin errors++; $display("FAIL mon_mirror got %b/%h exp 1/0298", mon_valid, mon_word); end
`endif
        done = 1'b0; step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_encode();
        test_full();
        test_flush();
        test_back_to_back();
        test_reset_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
